// File: rtl/sopc_pio_out_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sopc_pio_out_arb
//  Description : Round-robin arbiter/sequencer sharing a 32-bit SOPC output
//                PIO between NREQ requesters. Each accepted WRITE/SET/CLEAR
//                (or timed PULSE) op becomes single-cycle Avalon-MM writes
//                to PIO offsets 0/4/5. A shadow copy of the PIO output is kept.
//                Optional macro PIO_ARB_PULSE_EN enables the PULSE op
//                (set, hold PULSE_CYCLES, clear); without it op 3 acts as SET.
//  Revision    : 1.0 - initial release
// ============================================================================
module sopc_pio_out_arb #(
  parameter int NREQ         = 4,
  parameter int PULSE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [2:0]           avm_address,
  output logic                 avm_chipselect,
  output logic                 avm_write_n,
  output logic [31:0]          avm_writedata,
  output logic [31:0]          shadow,
  output logic                 busy
);

  localparam int GW = $clog2(NREQ);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_SET   = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_PULSE = 2'd3;

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_SET   = 3'd4;
  localparam logic [2:0] ADDR_CLEAR = 3'd5;

  // Elaboration-time guard on the supported parameter range.
  if (NREQ < 2 || NREQ > 8 || PULSE_CYCLES < 1) begin : g_param_check
    $error("sopc_pio_out_arb: NREQ must be 2..8 and PULSE_CYCLES >= 1");
  end

`ifdef PIO_ARB_PULSE_EN
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    PULSE_WAIT = 2'd2,
    PULSE_CLR  = 2'd3
  } state_t;
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
  logic [15:0] cnt;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;
`endif

  state_t          state, state_nx;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant_idx;
  logic [GW-1:0]   idx;
  logic            found;
  logic [1:0]      sel_op;
  logic [31:0]     sel_data;
  logic [1:0]      op_q;
  logic [31:0]     data_q;
  logic            accept;

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Mux out the winning requester's op and data.
  always_comb begin
    sel_op   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == GW'(i)) begin
        sel_op   = req_op[2*i +: 2];
        sel_data = req_data[32*i +: 32];
      end
    end
  end

  assign accept = (state == IDLE) && found;
  assign busy   = (state != IDLE);

  // Ready is a one-hot strobe to the winner while idle, forced low in reset.
  always_comb begin
    req_ready = '0;
    if (!reset && accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and bus outputs; the bus is idle unless a write is issued.
  always_comb begin
    state_nx       = state;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = ADDR_DATA;
    avm_writedata  = 32'd0;
    case (state)
      IDLE: begin
        if (found) state_nx = ISSUE;
      end
      ISSUE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = data_q;
        if (op_q == OP_WRITE)      avm_address = ADDR_DATA;
        else if (op_q == OP_CLEAR) avm_address = ADDR_CLEAR;
        else                       avm_address = ADDR_SET;
`ifdef PIO_ARB_PULSE_EN
        state_nx = (op_q == OP_PULSE) ? PULSE_WAIT : IDLE;
`else
        state_nx = IDLE;
`endif
      end
`ifdef PIO_ARB_PULSE_EN
      PULSE_WAIT: begin
        if (cnt == 16'd0) state_nx = PULSE_CLR;
      end
      PULSE_CLR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = ADDR_CLEAR;
        avm_writedata  = data_q;
        state_nx       = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Capture the accepted op and track the PIO contents after each write.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GW'(NREQ - 1);
      op_q       <= OP_WRITE;
      data_q     <= 32'd0;
      shadow     <= 32'd0;
    end else begin
      if (accept) begin
        op_q       <= sel_op;
        data_q     <= sel_data;
        last_grant <= grant_idx;
      end
      if (state == ISSUE) begin
        case (op_q)
          OP_WRITE:         shadow <= data_q;
          OP_SET, OP_PULSE: shadow <= shadow | data_q;
          default:          shadow <= shadow & ~data_q;
        endcase
      end
`ifdef PIO_ARB_PULSE_EN
      if (state == PULSE_CLR) begin
        shadow <= shadow & ~data_q;
      end
`endif
    end
  end

`ifdef PIO_ARB_PULSE_EN
  // Hold-phase counter: loaded as the set write goes out, counts down to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 16'd0;
    end else if (state == ISSUE && state_nx == PULSE_WAIT) begin
      cnt <= PULSE_LOAD;
    end else if (state == PULSE_WAIT && cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sopc_pio_out_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sopc_pio_out_arb
//  Description : Self-checking bench for sopc_pio_out_arb. A transaction-level
//                model (rotating pointer, busy-until cycle, scheduled write
//                list, shadow word) predicts every output each cycle; directed
//                scenarios add literal expectations. Works with or without
//                PIO_ARB_PULSE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sopc_pio_out_arb;
  localparam int NREQ = 4;
  localparam int PC   = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [2:0]           avm_address;
  logic                 avm_chipselect;
  logic                 avm_write_n;
  logic [31:0]          avm_writedata;
  logic [31:0]          shadow;
  logic                 busy;

  sopc_pio_out_arb #(.NREQ(NREQ), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .shadow(shadow), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Requester op FIFOs (head/count per requester).
  logic [1:0]  rq_op [NREQ][16];
  logic [31:0] rq_d  [NREQ][16];
  int          rq_n  [NREQ];
  int          rq_h  [NREQ];

  // Model state.
  typedef struct {
    int          at;
    logic [2:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t         sched[$];
  int          lg      = NREQ - 1;
  int          free_at = 0;
  int          acc_cyc = -1;
  logic [31:0] ms      = 32'd0;

  // Observation logs.
  int          glog_c[$];
  int          glog_i[$];
  int          wlog_c[$];
  logic [2:0]  wlog_a[$];
  logic [31:0] wlog_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq_h[i] < rq_n[i]) begin
        req_valid[i]        = 1'b1;
        req_op[2*i +: 2]    = rq_op[i][rq_h[i]];
        req_data[32*i +: 32] = rq_d[i][rq_h[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_op[2*i +: 2]    = 2'd0;
        req_data[32*i +: 32] = 32'd0;
      end
    end
  endtask

  task automatic push(input int i, input logic [1:0] op, input logic [31:0] d);
    rq_op[i][rq_n[i]] = op;
    rq_d[i][rq_n[i]]  = d;
    rq_n[i]++;
    drive();
  endtask

  // Predict this cycle's outputs, compare, then advance the model.
  task automatic model_step(output int g);
    logic [NREQ-1:0] er;
    logic            ecs, ewn, eb;
    logic [2:0]      ea;
    logic [31:0]     ed;
    logic [1:0]      op;
    logic [31:0]     d;
    wr_t             w;
    wr_t             keep[$];
    g  = -1;
    er = '0;
    if (!reset && cyc >= free_at) begin
      for (int k = 1; k <= NREQ; k++) begin
        int i = (lg + k) % NREQ;
        if (g < 0 && rq_h[i] < rq_n[i]) g = i;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    ecs = 1'b0; ewn = 1'b1; ea = 3'd0; ed = 32'd0;
    foreach (sched[j]) begin
      if (sched[j].at == cyc) begin
        ecs = 1'b1; ewn = 1'b0; ea = sched[j].a; ed = sched[j].d;
      end
    end
    eb = (cyc > acc_cyc) && (cyc < free_at);

    chk("ready",     32'(req_ready),      32'(er));
    chk("chipsel",   32'(avm_chipselect), 32'(ecs));
    chk("write_n",   32'(avm_write_n),    32'(ewn));
    chk("address",   32'(avm_address),    32'(ea));
    chk("writedata", avm_writedata,       ed);
    chk("shadow",    shadow,              ms);
    chk("busy",      32'(busy),           32'(eb));

    if (!reset && req_ready != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          glog_c.push_back(cyc);
          glog_i.push_back(i);
        end
      end
    end
    if (avm_chipselect === 1'b1 && avm_write_n === 1'b0) begin
      wlog_c.push_back(cyc);
      wlog_a.push_back(avm_address);
      wlog_d.push_back(avm_writedata);
    end

    if (g >= 0) begin
      op = rq_op[g][rq_h[g]];
      d  = rq_d[g][rq_h[g]];
      lg = g;
      acc_cyc = cyc;
      w.at = cyc + 1;
      w.a  = (op == 2'd0) ? 3'd0 : (op == 2'd2) ? 3'd5 : 3'd4;
      w.d  = d;
      sched.push_back(w);
      free_at = cyc + 2;
`ifdef PIO_ARB_PULSE_EN
      if (op == 2'd3) begin
        w.at = cyc + 2 + PC;
        w.a  = 3'd5;
        sched.push_back(w);
        free_at = cyc + 3 + PC;
      end
`endif
    end
    if (ecs) begin
      if (ea == 3'd0)      ms = ed;
      else if (ea == 3'd4) ms = ms | ed;
      else                 ms = ms & ~ed;
    end
    foreach (sched[j]) if (sched[j].at > cyc) keep.push_back(sched[j]);
    sched = keep;
    if (reset) begin
      sched.delete();
      ms      = 32'd0;
      lg      = NREQ - 1;
      free_at = cyc + 1;
      acc_cyc = cyc;
    end
  endtask

  task automatic tick();
    int g;
    @(negedge clk);
    model_step(g);
    @(posedge clk);
    #1;
    if (g >= 0) rq_h[g]++;
    cyc++;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int t, n0, n5;
    for (int i = 0; i < NREQ; i++) begin
      rq_n[i] = 0;
      rq_h[i] = 0;
    end
    reset = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    // Reset state (model checks all outputs during this cycle).
    tick();
    reset = 1'b0;
    tick();

    // Single WRITE from requester 0.
    push(0, 2'd0, 32'hA5A5_0000);
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t1_addr",  32'(avm_address), 32'd0);
    chk("t1_wn",    32'(avm_write_n), 32'd0);
    chk("t1_wdata", avm_writedata, 32'hA5A5_0000);
    tick();
    chk("t1_shadow", shadow, 32'hA5A5_0000);
    run(2);

    // SET then CLEAR on a known shadow.
    push(0, 2'd0, 32'hFF00_00FF);
    run(3);
    push(0, 2'd1, 32'h0000_0F00);
    push(0, 2'd2, 32'h0000_00F0);
    tick();
    chk("t2_set_addr", 32'(avm_address), 32'd4);
    tick();
    chk("t2_shadow_set", shadow, 32'hFF00_0FFF);
    tick();
    chk("t2_clr_addr", 32'(avm_address), 32'd5);
    tick();
    chk("t2_shadow_clr", shadow, 32'hFF00_0F0F);
    run(2);

    // All four requesters busy: rotation 0,1,2,3,0,... two cycles apart.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    glog_c.delete();
    glog_i.delete();
    for (int i = 0; i < NREQ; i++) begin
      push(i, 2'd0, 32'(i * 16 + 1));
      push(i, 2'd0, 32'(i * 16 + 2));
    end
    run(18);
    chk("t3_grant_count", 32'(glog_i.size()), 32'd8);
    if (glog_i.size() >= 8) begin
      for (int n = 0; n < 8; n++) begin
        chk("t3_grant_idx", 32'(glog_i[n]), 32'(n % 4));
        chk("t3_grant_gap", 32'(glog_c[n] - glog_c[0]), 32'(2 * n));
      end
    end

    // Requester 2 arrives while requester 1 is served.
    glog_c.delete();
    glog_i.delete();
    push(1, 2'd0, 32'h1111_1111);
    tick();
    push(2, 2'd0, 32'h2222_2222);
    run(4);
    chk("t6_grant_count", 32'(glog_i.size()), 32'd2);
    if (glog_i.size() >= 2) begin
      chk("t6_first",  32'(glog_i[0]), 32'd1);
      chk("t6_second", 32'(glog_i[1]), 32'd2);
      chk("t6_gap",    32'(glog_c[1] - glog_c[0]), 32'd2);
    end

    // PULSE 0x1.
    wlog_c.delete(); wlog_a.delete(); wlog_d.delete();
    t = cyc;
    push(0, 2'd3, 32'h0000_0001);
    run(12);
`ifdef PIO_ARB_PULSE_EN
    chk("t4_write_count", 32'(wlog_c.size()), 32'd2);
    if (wlog_c.size() >= 2) begin
      chk("t4_set_cyc",  32'(wlog_c[0] - t), 32'd1);
      chk("t4_set_addr", 32'(wlog_a[0]), 32'd4);
      chk("t4_clr_cyc",  32'(wlog_c[1] - t), 32'd6);
      chk("t4_clr_addr", 32'(wlog_a[1]), 32'd5);
      chk("t4_clr_data", wlog_d[1], 32'h1);
    end
`else
    chk("t4_write_count", 32'(wlog_c.size()), 32'd1);
    if (wlog_c.size() >= 1) begin
      chk("t4_set_cyc",  32'(wlog_c[0] - t), 32'd1);
      chk("t4_set_addr", 32'(wlog_a[0]), 32'd4);
    end
`endif

    // Reset during the pulse hold phase.
    wlog_c.delete(); wlog_a.delete(); wlog_d.delete();
    push(0, 2'd3, 32'h0000_0002);
    run(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t5_shadow",  shadow, 32'd0);
    chk("t5_busy",    32'(busy), 32'd0);
    chk("t5_chipsel", 32'(avm_chipselect), 32'd0);
    run(10);
    n0 = 0;
    n5 = 0;
    foreach (wlog_a[j]) begin
      if (wlog_a[j] == 3'd5) n5++;
      else n0++;
    end
    chk("t5_set_writes",   32'(n0), 32'd1);
    chk("t5_clear_writes", 32'(n5), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
